// File: rtl/mmp_iddmm_seq.sv
// Sequencer for the IDDMM Montgomery-multiply PE array: walks the (i, j) word grid,
// strobes the PEs, addresses the operand RAMs and hands the result to the final subtract.
module mmp_iddmm_seq #(
    parameter int N      = 32,
    parameter int LAT    = 8,
    parameter int ISSUE2 = 0,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              task_req,
    input  logic [ADDR_W:0]   task_nw,
    input  logic              task_abort,
    output logic              task_busy,
    output logic              task_done,
    output logic              ctl_carry_clr,
    output logic              ctl_carry_ena,
    output logic              ctl_carry_sel,
    output logic              ctl_c_pre_clr,
    output logic              ctl_c_pre_ena,
    output logic              ctl_q_ena,
    input  logic              carry,
    output logic              comp_req,
    input  logic              comp_end,
    output logic              ref_an,
    output logic [ADDR_W:0]   ref_addr_rdx,
    output logic [ADDR_W-1:0] ref_addr_rdy,
    output logic [ADDR_W-1:0] ref_addr_rdm,
    output logic [ADDR_W-1:0] ref_addr_rda,
    output logic              ref_wr_n,
    output logic [ADDR_W-1:0] ref_wr_a_addr,
    output logic              ref_wr_a_ena
);

    typedef enum logic [2:0] {IDLE, INIT, PRIME, SCAN, DRAIN, FINSUB} state_t;

    localparam logic [ADDR_W:0]   NMAX     = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   JONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IONE     = ADDR_W'(1);
    localparam bit                ISS_EACH = (ISSUE2 == 0);

    state_t state, next_state;

    logic [ADDR_W-1:0] i;
    logic [ADDR_W:0]   j;
    logic [ADDR_W:0]   nw;
    logic              j00;
    logic              phase;

    logic [LAT-1:0]             vld_pipe;
    logic [LAT-1:0][ADDR_W:0]   j_pipe;

    logic              issue;
    logic              j_end;
    logic              row_last;
    logic              pipe_busy;
    logic [ADDR_W:0]   nw_clamp;
    logic              carry_clr_d, carry_ena_d, carry_sel_d, c_pre_clr_d;

    assign j_end     = (j == nw);
    assign row_last  = ({1'b0, i} == (nw - JONE));
    assign pipe_busy = |vld_pipe;
    assign nw_clamp  = ((task_nw == '0) || (task_nw > NMAX)) ? NMAX : task_nw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (task_abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (task_req) next_state = INIT;
                INIT:    next_state = PRIME;
                PRIME:   next_state = SCAN;
                SCAN:    if (issue && j_end) next_state = row_last ? DRAIN : PRIME;
                DRAIN:   if (!pipe_busy) next_state = FINSUB;
                FINSUB:  if (comp_end) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        issue       = (state == SCAN) && (ISS_EACH || phase);
        carry_clr_d = issue && (i == '0) && (j == '0);
        carry_ena_d = issue && j_end;
        carry_sel_d = (state == SCAN) && j_end;
        c_pre_clr_d = issue && (j == '0);
    end

    // Counters, strobes and handshake; abort wins over everything except reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i             <= '0;
            j             <= '0;
            nw            <= '0;
            j00           <= 1'b0;
            phase         <= 1'b0;
            task_busy     <= 1'b0;
            task_done     <= 1'b0;
            comp_req      <= 1'b0;
            ref_an        <= 1'b0;
            ctl_carry_clr <= 1'b0;
            ctl_carry_ena <= 1'b0;
            ctl_carry_sel <= 1'b0;
            ctl_c_pre_clr <= 1'b0;
            ctl_c_pre_ena <= 1'b0;
            ref_wr_n      <= 1'b0;
            vld_pipe      <= '0;
        end else if (task_abort) begin
            i             <= '0;
            j             <= '0;
            j00           <= 1'b0;
            phase         <= 1'b0;
            task_busy     <= 1'b0;
            task_done     <= 1'b0;
            comp_req      <= 1'b0;
            ctl_carry_clr <= 1'b0;
            ctl_carry_ena <= 1'b0;
            ctl_carry_sel <= 1'b0;
            ctl_c_pre_clr <= 1'b0;
            ctl_c_pre_ena <= 1'b0;
            ref_wr_n      <= 1'b0;
            vld_pipe      <= '0;
        end else begin
            task_done     <= 1'b0;
            ctl_carry_clr <= carry_clr_d;
            ctl_carry_ena <= carry_ena_d;
            ctl_carry_sel <= carry_sel_d;
            ctl_c_pre_clr <= c_pre_clr_d;
            ctl_c_pre_ena <= issue;
            ref_wr_n      <= carry_sel_d;
            phase         <= ((state == SCAN) && !j00) ? ~phase : 1'b0;
            vld_pipe[0]   <= issue;
            for (int k = 1; k < LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
            case (state)
                IDLE: if (task_req) begin
                    nw        <= nw_clamp;
                    task_busy <= 1'b1;
                end
                INIT: begin
                    j00 <= 1'b1;
                    i   <= '0;
                    j   <= '0;
                end
                PRIME: j00 <= 1'b0;
                SCAN: if (issue) begin
                    if (!j_end) begin
                        j <= j + JONE;
                    end else if (!row_last) begin
                        j   <= '0;
                        i   <= i + IONE;
                        j00 <= 1'b1;
                    end else begin
                        i <= '0;
                        j <= '0;
                    end
                end
                DRAIN: if (!pipe_busy) begin
                    ref_an   <= carry;
                    comp_req <= 1'b1;
                end
                FINSUB: if (comp_end) begin
                    comp_req  <= 1'b0;
                    task_done <= 1'b1;
                    task_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Column index travels alongside the valid bits so write-back lines up with PE output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_pipe <= '0;
        end else begin
            j_pipe[0] <= j;
            for (int k = 1; k < LAT; k++) j_pipe[k] <= j_pipe[k-1];
        end
    end

    assign ctl_q_ena     = ctl_c_pre_clr;
    assign ref_addr_rdx  = j;
    assign ref_addr_rdy  = i;
    assign ref_addr_rdm  = j[ADDR_W-1:0];
    assign ref_addr_rda  = j[ADDR_W-1:0];
    assign ref_wr_a_ena  = vld_pipe[LAT-1] && (j_pipe[LAT-1] != '0);
    assign ref_wr_a_addr = ref_wr_a_ena ? (j_pipe[LAT-1][ADDR_W-1:0] - IONE) : '0;

endmodule
